// File: rtl/char_write_arbiter.sv
// Character-RAM write controller: round-robin arbiter for two text producers, {row,col} packing.
// Defining CHAR_CLEAR_EN also builds the full-screen clear sweep (CLEAR state, counter, clr_busy).
module char_write_arbiter #(
  parameter logic [6:0] FILL_CHAR = 7'h20,
  parameter logic [9:0] CLR_LAST  = 10'd1023
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_row,
  input  logic [5:0] req0_col,
  input  logic [6:0] req0_char,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_row,
  input  logic [5:0] req1_col,
  input  logic [6:0] req1_char,
  input  logic       clr_req,
  output logic       clr_busy,
  output logic       ram_we,
  output logic [9:0] ram_addr,
  output logic [6:0] ram_din
);
  localparam int unsigned ROW_W  = 4;
  localparam int unsigned COL_W  = 6;
  localparam int unsigned CHAR_W = 7;
  localparam int unsigned ADDR_W = ROW_W + COL_W;

  logic              last;     // 1 when req1 holds the most recent grant
  logic              gnt0;
  logic              gnt1;
  logic              blocked;
  logic              hs0;
  logic              hs1;
  logic              hs_any;
  logic [ADDR_W-1:0] hs_addr;
  logic [CHAR_W-1:0] hs_char;

  // Round-robin: a lone requester always wins, a tie goes to the one not granted last.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0_valid && req1_valid) begin
      gnt0 = last;
      gnt1 = !last;
    end else begin
      gnt0 = req0_valid;
      gnt1 = req1_valid;
    end
  end

  assign req0_ready = gnt0 && !blocked;
  assign req1_ready = gnt1 && !blocked;

  // A ready is only ever raised for a valid requester, so ready alone marks the handshake.
  assign hs0    = req0_ready;
  assign hs1    = req1_ready;
  assign hs_any = hs0 || hs1;

  always_comb begin
    hs_addr = {req0_row, req0_col};
    hs_char = req0_char;
    if (hs1) begin
      hs_addr = {req1_row, req1_col};
      hs_char = req1_char;
    end
  end

`ifdef CHAR_CLEAR_EN
  typedef enum logic {SERVE, CLEAR} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;

  assign blocked = !rst_n || clr_req || (state == CLEAR);

  // Serve/clear controller; the counter always equals the address being written in CLEAR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SERVE;
      last     <= 1'b1;
      cnt      <= '0;
      clr_busy <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
    end else begin
      case (state)
        SERVE: begin
          if (clr_req) begin
            state    <= CLEAR;
            clr_busy <= 1'b1;
            cnt      <= '0;
            ram_we   <= 1'b1;
            ram_addr <= '0;
            ram_din  <= FILL_CHAR;
          end else begin
            ram_we <= hs_any;
            if (hs_any) begin
              ram_addr <= hs_addr;
              ram_din  <= hs_char;
              last     <= hs1;
            end
          end
        end
        CLEAR: begin
          if (cnt == CLR_LAST) begin
            state    <= SERVE;
            clr_busy <= 1'b0;
            ram_we   <= 1'b0;
          end else begin
            cnt      <= cnt + ADDR_W'(1);
            ram_addr <= cnt + ADDR_W'(1);
            ram_we   <= 1'b1;
          end
        end
      endcase
    end
  end
`else
  logic unused_cfg;

  // Without the sweep the clear request and fill parameters have no consumer.
  assign unused_cfg = ^{clr_req, FILL_CHAR, CLR_LAST};
  assign blocked    = !rst_n;
  assign clr_busy   = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last     <= 1'b1;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
    end else begin
      ram_we <= hs_any;
      if (hs_any) begin
        ram_addr <= hs_addr;
        ram_din  <= hs_char;
        last     <= hs1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_char_write_arbiter.sv
// Bench for char_write_arbiter: directed scenarios plus randomized traffic against a behavioural model.
// Clear-sweep scenarios run when CHAR_CLEAR_EN is defined; otherwise clr_req must have no effect.
module tb_char_write_arbiter;
  logic       clk;
  logic       rst_n;
  logic       req0_valid;
  logic       req0_ready;
  logic [3:0] req0_row;
  logic [5:0] req0_col;
  logic [6:0] req0_char;
  logic       req1_valid;
  logic       req1_ready;
  logic [3:0] req1_row;
  logic [5:0] req1_col;
  logic [6:0] req1_char;
  logic       clr_req;
  logic       clr_busy;
  logic       ram_we;
  logic [9:0] ram_addr;
  logic [6:0] ram_din;

  int         total;
  int         bad;
  int         m_last;    // requester granted most recently (1 after reset)
  logic [9:0] exp_addr;
  logic [6:0] exp_din;

  char_write_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_row(req0_row), .req0_col(req0_col), .req0_char(req0_char),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_row(req1_row), .req1_col(req1_col), .req1_char(req1_char),
    .clr_req(clr_req), .clr_busy(clr_busy),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din)
  );

  always #5 clk = ~clk;

  // Leaves the bench just after a rising edge with reset released and no requests.
  task automatic apply_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    clr_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    m_last = 1;
    exp_addr = '0;
    exp_din = '0;
  endtask

  task automatic test_reset();
    req0_valid = 1'b1;
    req0_row = 4'd2; req0_col = 6'd5; req0_char = 7'h41;
    @(negedge clk); #1;
    total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL reset_we: got %0b want 0", ram_we); end
    total++; if (ram_addr !== 10'h000) begin bad++; $display("FAIL reset_addr: got %h want 000", ram_addr); end
    total++; if (ram_din !== 7'h00) begin bad++; $display("FAIL reset_din: got %h want 00", ram_din); end
    total++; if (clr_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", clr_busy); end
    total++; if (req0_ready !== 1'b0) begin bad++; $display("FAIL reset_ready0: got %0b want 0", req0_ready); end
    total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL reset_ready1: got %0b want 0", req1_ready); end
    rst_n = 1'b1;
    #1;
    total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL first_ready0: got %0b want 1", req0_ready); end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    total++; if (ram_we !== 1'b1) begin bad++; $display("FAIL first_we: got %0b want 1", ram_we); end
    total++; if (ram_addr !== 10'h085) begin bad++; $display("FAIL first_addr: got %h want 085", ram_addr); end
    total++; if (ram_din !== 7'h41) begin bad++; $display("FAIL first_din: got %h want 41", ram_din); end
    m_last = 0;
    exp_addr = 10'h085;
    exp_din = 7'h41;
  endtask

  task automatic test_tie();
    apply_reset();
    req0_valid = 1'b1; req0_row = 4'd0;  req0_col = 6'd0;  req0_char = 7'h41;
    req1_valid = 1'b1; req1_row = 4'd15; req1_col = 6'd63; req1_char = 7'h42;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      total++; if (req0_ready !== 1'((i % 2) == 0)) begin bad++; $display("FAIL tie_ready0[%0d]: got %0b want %0b", i, req0_ready, (i % 2) == 0); end
      total++; if (req1_ready !== 1'((i % 2) == 1)) begin bad++; $display("FAIL tie_ready1[%0d]: got %0b want %0b", i, req1_ready, (i % 2) == 1); end
      @(posedge clk); #1;
      total++; if (ram_we !== 1'b1) begin bad++; $display("FAIL tie_we[%0d]: got %0b want 1", i, ram_we); end
      total++; if (ram_addr !== ((i % 2) == 0 ? 10'h000 : 10'h3FF)) begin bad++; $display("FAIL tie_addr[%0d]: got %h", i, ram_addr); end
      total++; if (ram_din !== ((i % 2) == 0 ? 7'h41 : 7'h42)) begin bad++; $display("FAIL tie_din[%0d]: got %h", i, ram_din); end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    m_last = 1;
    exp_addr = 10'h3FF;
    exp_din = 7'h42;
  endtask

  // clr_mode: 0 keeps clr_req low, 1 randomizes it, 2 holds it high.
  task automatic test_random(input int cycles, input int clr_mode);
    bit acc0;
    bit acc1;
    int win;
    acc0 = 1'b1;
    acc1 = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      if (!req0_valid || acc0) begin
        req0_valid = ($urandom_range(0, 99) < 65);
        req0_row = 4'($urandom); req0_col = 6'($urandom); req0_char = 7'($urandom);
      end
      if (!req1_valid || acc1) begin
        req1_valid = ($urandom_range(0, 99) < 65);
        req1_row = 4'($urandom); req1_col = 6'($urandom); req1_char = 7'($urandom);
      end
      clr_req = (clr_mode == 2) ? 1'b1 : (clr_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk); #1;
      win = -1;
      if (req0_valid && req1_valid) win = 1 - m_last;
      else if (req0_valid) win = 0;
      else if (req1_valid) win = 1;
      total++; if (req0_ready !== 1'(win == 0)) begin bad++; $display("FAIL rnd_ready0[%0d]: got %0b want %0b", c, req0_ready, win == 0); end
      total++; if (req1_ready !== 1'(win == 1)) begin bad++; $display("FAIL rnd_ready1[%0d]: got %0b want %0b", c, req1_ready, win == 1); end
      acc0 = (win == 0);
      acc1 = (win == 1);
      if (win == 0) begin exp_addr = {req0_row, req0_col}; exp_din = req0_char; end
      if (win == 1) begin exp_addr = {req1_row, req1_col}; exp_din = req1_char; end
      @(posedge clk); #1;
      total++; if (ram_we !== 1'(win >= 0)) begin bad++; $display("FAIL rnd_we[%0d]: got %0b want %0b", c, ram_we, win >= 0); end
      total++; if (ram_addr !== exp_addr) begin bad++; $display("FAIL rnd_addr[%0d]: got %h want %h", c, ram_addr, exp_addr); end
      total++; if (ram_din !== exp_din) begin bad++; $display("FAIL rnd_din[%0d]: got %h want %h", c, ram_din, exp_din); end
      total++; if (clr_busy !== 1'b0) begin bad++; $display("FAIL rnd_busy[%0d]: got %0b want 0", c, clr_busy); end
      if (win >= 0) m_last = win;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    clr_req = 1'b0;
  endtask

`ifdef CHAR_CLEAR_EN
  // Checks one full sweep starting at the current cycle; rereq_at re-raises clr_req mid-sweep.
  task automatic check_sweep(input string tag, input int rereq_at);
    for (int i = 0; i < 1024; i++) begin
      clr_req = (rereq_at >= 0 && i >= rereq_at && i < rereq_at + 10);
      total++; if (ram_we !== 1'b1) begin bad++; $display("FAIL %s_we[%0d]: got %0b want 1", tag, i, ram_we); end
      total++; if (ram_addr !== 10'(i)) begin bad++; $display("FAIL %s_addr[%0d]: got %h want %h", tag, i, ram_addr, 10'(i)); end
      total++; if (ram_din !== 7'h20) begin bad++; $display("FAIL %s_din[%0d]: got %h want 20", tag, i, ram_din); end
      total++; if (clr_busy !== 1'b1) begin bad++; $display("FAIL %s_busy[%0d]: got %0b want 1", tag, i, clr_busy); end
      @(negedge clk);
      total++; if (req0_ready !== 1'b0) begin bad++; $display("FAIL %s_ready0[%0d]: got %0b want 0", tag, i, req0_ready); end
      @(posedge clk); #1;
    end
    clr_req = 1'b0;
    total++; if (clr_busy !== 1'b0) begin bad++; $display("FAIL %s_busy_end: got %0b want 0", tag, clr_busy); end
    total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL %s_we_end: got %0b want 0", tag, ram_we); end
    exp_addr = 10'h3FF;
    exp_din = 7'h20;
  endtask

  task automatic test_clear();
    req0_valid = 1'b1; req0_row = 4'd3; req0_col = 6'd7; req0_char = 7'h55;
    clr_req = 1'b1;
    @(negedge clk); #1;
    total++; if (req0_ready !== 1'b0) begin bad++; $display("FAIL clr_gate_ready0: got %0b want 0", req0_ready); end
    @(posedge clk); #1;
    clr_req = 1'b0;
    check_sweep("clr", -1);
    @(negedge clk); #1;
    total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL clr_after_ready0: got %0b want 1", req0_ready); end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    total++; if (ram_we !== 1'b1) begin bad++; $display("FAIL clr_after_we: got %0b want 1", ram_we); end
    total++; if (ram_addr !== 10'h0C7) begin bad++; $display("FAIL clr_after_addr: got %h want 0c7", ram_addr); end
    total++; if (ram_din !== 7'h55) begin bad++; $display("FAIL clr_after_din: got %h want 55", ram_din); end
    m_last = 0;
    exp_addr = 10'h0C7;
    exp_din = 7'h55;
  endtask

  task automatic test_clear_priority();
    req1_valid = 1'b1; req1_row = 4'd9; req1_col = 6'd33; req1_char = 7'h33;
    @(negedge clk); #1;
    total++; if (req1_ready !== 1'b1) begin bad++; $display("FAIL prio_ready1: got %0b want 1", req1_ready); end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    clr_req = 1'b1;
    total++; if (ram_we !== 1'b1) begin bad++; $display("FAIL prio_we: got %0b want 1", ram_we); end
    total++; if (ram_addr !== 10'h261) begin bad++; $display("FAIL prio_addr: got %h want 261", ram_addr); end
    total++; if (ram_din !== 7'h33) begin bad++; $display("FAIL prio_din: got %h want 33", ram_din); end
    m_last = 1;
    @(posedge clk); #1;
    check_sweep("rereq", 500);
  endtask

  task automatic test_reset_mid();
    clr_req = 1'b1;
    @(posedge clk); #1;
    clr_req = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
    end
    total++; if (ram_addr !== 10'd300) begin bad++; $display("FAIL mid_addr: got %0d want 300", ram_addr); end
    total++; if (clr_busy !== 1'b1) begin bad++; $display("FAIL mid_busy: got %0b want 1", clr_busy); end
    req1_valid = 1'b1; req1_row = 4'd4; req1_col = 6'd10; req1_char = 7'h61;
    rst_n = 1'b0;
    #1;
    total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL mid_rst_we: got %0b want 0", ram_we); end
    total++; if (clr_busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %0b want 0", clr_busy); end
    total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready1: got %0b want 0", req1_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    m_last = 1;
    #1;
    total++; if (req1_ready !== 1'b1) begin bad++; $display("FAIL mid_rel_ready1: got %0b want 1", req1_ready); end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    total++; if (ram_we !== 1'b1) begin bad++; $display("FAIL mid_rel_we: got %0b want 1", ram_we); end
    total++; if (ram_addr !== 10'h10A) begin bad++; $display("FAIL mid_rel_addr: got %h want 10a", ram_addr); end
    total++; if (ram_din !== 7'h61) begin bad++; $display("FAIL mid_rel_din: got %h want 61", ram_din); end
    total++; if (clr_busy !== 1'b0) begin bad++; $display("FAIL mid_rel_busy: got %0b want 0", clr_busy); end
    exp_addr = 10'h10A;
    exp_din = 7'h61;
  endtask
`else
  task automatic test_macro_off();
    clr_req = 1'b1;
    req0_valid = 1'b1; req0_row = 4'd1; req0_col = 6'd1; req0_char = 7'h5A;
    @(negedge clk); #1;
    total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL off_ready0: got %0b want 1", req0_ready); end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    total++; if (ram_addr !== 10'h041) begin bad++; $display("FAIL off_addr: got %h want 041", ram_addr); end
    total++; if (clr_busy !== 1'b0) begin bad++; $display("FAIL off_busy: got %0b want 0", clr_busy); end
    m_last = 0;
    exp_addr = 10'h041;
    exp_din = 7'h5A;
    test_random(150, 2);
    test_random(150, 1);
  endtask
`endif

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_row = '0; req0_col = '0; req0_char = '0;
    req1_valid = 1'b0; req1_row = '0; req1_col = '0; req1_char = '0;
    clr_req = 1'b0;
    total = 0;
    bad = 0;
    m_last = 1;
    exp_addr = '0;
    exp_din = '0;
    test_reset();
    test_tie();
    test_random(300, 0);
`ifdef CHAR_CLEAR_EN
    test_clear();
    test_clear_priority();
    test_reset_mid();
    test_random(100, 0);
`else
    test_macro_off();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/char_write_arbiter.md
# char_write_arbiter

Write-side controller for the on-screen character RAM. It shares the single character-RAM write port between two independent text producers with round-robin arbitration, packs each request's row/column into the RAM address, and optionally runs a full-screen clear sweep. It sits between the display-content logic and the character-RAM write port (`we`/`addr`/`din`) of the upper-screen character renderer.

## Interface
- `FILL_CHAR`, default 7'h20: ASCII code written by the clear sweep (space).
- `CLR_LAST`, default 10'd1023: last address written by the clear sweep; the sweep covers 16 rows × 64 columns.

- `clk` input 1: system clock; all logic on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req0_valid` input 1: requester 0 holds one character write.
- `req0_ready` output 1: requester 0 write accepted this cycle.
- `req0_row` input 4: text row, 0–15.
- `req0_col` input 6: text column, 0–63.
- `req0_char` input 7: ASCII code.
- `req1_valid`, `req1_ready`, `req1_row`, `req1_col`, `req1_char`: same widths and meanings for requester 1.
- `clr_req` input 1: start a clear sweep. Level is sampled each cycle.
- `clr_busy` output 1: a clear sweep is in progress.
- `ram_we` output 1: character-RAM write enable.
- `ram_addr` output 10: character-RAM address, formed as `{row, col}`.
- `ram_din` output 7: character-RAM write data.

## Operation
- States are SERVE and CLEAR. Reset enters SERVE.
- **SERVE state**
  - A handshake occurs when `reqN_valid` and `reqN_ready` are both high.
  - `reqN_ready` is combinational. It is high only for the granted requester, and only when `clr_req`=0.
  - If only one requester is valid, that requester is granted.
  - If both are valid, the requester not granted last is granted. The `last` pointer resets to 1, so req0 wins the first tie.
  - The `last` pointer updates only on a handshake.
- **Write output**
  - A handshake in cycle N registers `ram_we`=1 in cycle N+1, with `ram_addr={row,col}` and `ram_din=char` of the winner.
  - With no handshake, `ram_we`=0 in the next cycle. `ram_addr` and `ram_din` hold their previous values.
- **Clear entry**
  - `clr_req`=1 in SERVE during cycle N moves the block to CLEAR at N+1.
  - `clr_req` has priority: no request handshake occurs in cycle N.
- **CLEAR state**
  - An internal 10-bit counter starts at 0.
  - Each cycle: `ram_we`=1, `ram_addr`=counter, `ram_din`=FILL_CHAR, counter increments.
  - After writing CLR_LAST the block returns to SERVE.
  - Both readies are 0 throughout CLEAR.
  - `clr_req` is ignored during CLEAR; there is no restart and no queuing.
  - `clr_busy`=1 exactly while in CLEAR.
- Requesters must hold valid and payload stable until ready. The block does not buffer requests.

## Timing
- Reset values: `ram_we`=0, `ram_addr`=0, `ram_din`=0, `clr_busy`=0, state=SERVE, `last`=1, counter=0.
- Readies are 0 while `rst_n`=0.
- Write latency: 1 cycle from handshake to `ram_we`.
- Throughput: one write per cycle. Two continuously valid requesters alternate 0,1,0,1…
- Clear sweep with `clr_req` seen in cycle N:
  - writes occupy cycles N+1 through N+1024;
  - `clr_busy` is high during N+1..N+1024;
  - readies may rise again at N+1025.
- A handshake in cycle N-1 still produces its write at N, before the sweep begins.
- Reset asserted mid-sweep aborts the sweep immediately. The partially cleared RAM is left as is, and the block resumes in SERVE after reset release.
- Row and column values are never range-checked; all 4+6-bit combinations are legal addresses.

## Configuration
- `CHAR_CLEAR_EN` defined:
  - the CLEAR state, the counter and `clr_busy` are built;
  - `clr_req` is honoured and gates the readies.
- `CHAR_CLEAR_EN` undefined:
  - no CLEAR state and no counter;
  - `clr_req` is ignored, including for ready gating;
  - `clr_busy` is tied to 0;
  - only arbitration and write formatting remain.

## Test plan
1. **Reset values.** With `rst_n`=0, all outputs are 0. Release reset and assert `req0_valid` with row=2, col=5, char=0x41. Expect `req0_ready`=1 the same cycle, then next cycle `ram_we`=1, `ram_addr`=0x085, `ram_din`=0x41.
2. **Tie arbitration.** Hold both requesters valid for 4 cycles: req0 with (0,0,'A'), req1 with (15,63,'B'). Expect grants in order 0,1,0,1. Expect writes alternating 0x000/0x41 and 0x3FF/0x42, with `ram_we` high for 4 consecutive cycles.
3. **Clear sweep.** Pulse `clr_req` for 1 cycle while req0 is valid. Expect:
   - `req0_ready`=0 that cycle;
   - 1024 consecutive writes of 0x20 at addresses 0..1023;
   - `clr_busy` high exactly 1024 cycles;
   - req0 accepted in the first cycle after the sweep.
4. **Clear priority and re-request.** Assert a handshake one cycle before `clr_req`. Expect that write to appear, then the sweep. Re-assert `clr_req` mid-sweep and expect no extension past 1024 writes.
5. **Reset mid-sweep.** Assert `rst_n`=0 at sweep address 300. Expect `ram_we`=0 and `clr_busy`=0 immediately. After release, a req1 write is accepted normally.
6. **Macro off.** Build without `CHAR_CLEAR_EN` and hold `clr_req`=1. Expect `clr_busy`=0 and request handshakes unaffected.
